// File: rtl/cmp_sweep_pkg.sv
// Shared types and helpers for the comparator sweep BIST controller.
// Optional build macro: CMP_SWEEP_HALT_ON_FAIL_EN (stop the sweep at the first mismatch).
package cmp_sweep_pkg;

   // Controller states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Number of {A,B} vectors in a full sweep for a given operand width
   function automatic int unsigned num_vec(input int unsigned width);
      return 32'd1 << (2 * width);
   endfunction

   // Golden {gt, lt, eq} triple for a pair of operands
   function automatic logic [2:0] exp_triple(input int unsigned a, input int unsigned b);
      return {a > b, a < b, a == b};
   endfunction

endpackage

// File: rtl/cmp_sweep_ref.sv
// Combinational golden model: expected {gt, lt, eq} for the operands being driven.
module cmp_sweep_ref
   import cmp_sweep_pkg::*;
#(
   parameter int unsigned WIDTH = 3
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [2:0]       exp_gle
);

   // Reference triple straight from the package helper
   always_comb begin
      exp_gle = exp_triple(32'(a), 32'(b));
   end

endmodule

// File: rtl/cmp_sweep_ctrl.sv
// Built-in self-test sequencer for a WIDTH-bit magnitude comparator.
// Walks every {A,B} pair, waits SETTLE_CYCLES, checks GT/LT/EQ against a
// reference model and records error count, first failing pair and pass flag.
// Optional build macro: CMP_SWEEP_HALT_ON_FAIL_EN -- when defined, the first
// mismatch ends the sweep immediately with the failing operands left driven.
module cmp_sweep_ctrl
   import cmp_sweep_pkg::*;
#(
   parameter int unsigned WIDTH         = 3,
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic [WIDTH-1:0]   cmp_a,
   output logic [WIDTH-1:0]   cmp_b,
   input  logic               cmp_gt,
   input  logic               cmp_lt,
   input  logic               cmp_eq,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [2*WIDTH:0]   err_count,
   output logic               fail_seen,
   output logic [WIDTH-1:0]   first_fail_a,
   output logic [WIDTH-1:0]   first_fail_b
);

   localparam int unsigned IDX_W   = 2 * WIDTH;
   localparam int unsigned NUM_VEC = num_vec(WIDTH);
   localparam int unsigned CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

`ifdef CMP_SWEEP_HALT_ON_FAIL_EN
   localparam bit HALT_ON_FAIL = 1'b1;
`else
   localparam bit HALT_ON_FAIL = 1'b0;
`endif

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 pass_q, pass_d;
   logic [IDX_W:0]       err_q, err_d;
   logic                 fail_seen_q, fail_seen_d;
   logic [WIDTH-1:0]     ffa_q, ffa_d;
   logic [WIDTH-1:0]     ffb_q, ffb_d;

   logic [2:0]           exp_gle;
   logic                 mismatch;
   logic                 last_vec;
   logic                 settled;
   logic                 end_sweep;
   logic [IDX_W:0]       err_inc;

   // Operands come straight from the vector index register; B is the low half
   assign cmp_a = idx_q[IDX_W-1:WIDTH];
   assign cmp_b = idx_q[WIDTH-1:0];

   cmp_sweep_ref #(.WIDTH(WIDTH)) u_ref (
      .a       (cmp_a),
      .b       (cmp_b),
      .exp_gle (exp_gle)
   );

   // Non-one-hot outputs fail too, since any bit differing from the triple counts
   assign mismatch  = ({cmp_gt, cmp_lt, cmp_eq} != exp_gle);
   assign last_vec  = (idx_q == IDX_W'(NUM_VEC - 1));
   assign settled   = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
   assign end_sweep = last_vec | (HALT_ON_FAIL & mismatch);
   assign err_inc   = err_q + {{IDX_W{1'b0}}, mismatch};

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)     state_d = DRIVE;
         DRIVE:   if (settled)   state_d = CHECK;
         CHECK:   state_d = end_sweep ? DONE : DRIVE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and output next values per state
   always_comb begin
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      pass_d      = pass_q;
      err_d       = err_q;
      fail_seen_d = fail_seen_q;
      ffa_d       = ffa_q;
      ffb_d       = ffb_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               idx_d       = '0;
               cnt_d       = '0;
               busy_d      = 1'b1;
               pass_d      = 1'b0;
               err_d       = '0;
               fail_seen_d = 1'b0;
               ffa_d       = '0;
               ffb_d       = '0;
            end
         end
         DRIVE: begin
            cnt_d = settled ? '0 : cnt_q + 1'b1;
         end
         CHECK: begin
            err_d = err_inc;
            if (mismatch && !fail_seen_q) begin
               fail_seen_d = 1'b1;
               ffa_d       = cmp_a;
               ffb_d       = cmp_b;
            end
            if (end_sweep) begin
               done_d = 1'b1;
               pass_d = (err_inc == '0);
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            busy_d = 1'b0;
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q       <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_q       <= '0;
         fail_seen_q <= 1'b0;
         ffa_q       <= '0;
         ffb_q       <= '0;
      end else begin
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         err_q       <= err_d;
         fail_seen_q <= fail_seen_d;
         ffa_q       <= ffa_d;
         ffb_q       <= ffb_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign err_count    = err_q;
   assign fail_seen    = fail_seen_q;
   assign first_fail_a = ffa_q;
   assign first_fail_b = ffb_q;

endmodule

// File: tb/tb_cmp_sweep_ctrl.sv
// Directed bench for cmp_sweep_ctrl: a small comparator model with selectable
// faults, a table of full sweeps with hand-computed results, and a reset/abort sequence.
module tb_cmp_sweep_ctrl;

   localparam int W = 3;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic [W-1:0]   cmp_a, cmp_b;
   logic           cmp_gt, cmp_lt, cmp_eq;
   logic           busy, done, pass, fail_seen;
   logic [2*W:0]   err_count;
   logic [W-1:0]   first_fail_a, first_fail_b;

   int errors = 0;
   int checks = 0;
   int mode   = 0;   // 0 good, 1 gt stuck 1, 2 gt/lt swapped, 3 eq stuck 0

   always #5 clk = ~clk;

   cmp_sweep_ctrl #(.WIDTH(W), .SETTLE_CYCLES(1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .cmp_a        (cmp_a),
      .cmp_b        (cmp_b),
      .cmp_gt       (cmp_gt),
      .cmp_lt       (cmp_lt),
      .cmp_eq       (cmp_eq),
      .busy         (busy),
      .done         (done),
      .pass         (pass),
      .err_count    (err_count),
      .fail_seen    (fail_seen),
      .first_fail_a (first_fail_a),
      .first_fail_b (first_fail_b)
   );

   // Comparator under test, with injectable faults
   always_comb begin
      cmp_gt = (cmp_a > cmp_b);
      cmp_lt = (cmp_a < cmp_b);
      cmp_eq = (cmp_a == cmp_b);
      case (mode)
         1: begin cmp_gt = 1'b1; cmp_lt = 1'b0; cmp_eq = 1'b0; end
         2: begin cmp_gt = (cmp_a < cmp_b); cmp_lt = (cmp_a > cmp_b); end
         3: cmp_eq = 1'b0;
         default: ;
      endcase
   end

   typedef struct {
      int mode;
      int err;
      int pass;
      int fseen;
      int ffa;
      int ffb;
      int lat;
      int a;
      int b;
   } vec_t;

   vec_t tbl[4];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " cmp_a"},        int'(cmp_a), 0);
      chk({tag, " cmp_b"},        int'(cmp_b), 0);
      chk({tag, " busy"},         int'(busy), 0);
      chk({tag, " done"},         int'(done), 0);
      chk({tag, " pass"},         int'(pass), 0);
      chk({tag, " err_count"},    int'(err_count), 0);
      chk({tag, " fail_seen"},    int'(fail_seen), 0);
      chk({tag, " first_fail_a"}, int'(first_fail_a), 0);
      chk({tag, " first_fail_b"}, int'(first_fail_b), 0);
   endtask

   // Pulse start for one edge, then count edges until done (bounded)
   task automatic run_sweep(output int lat);
      lat = -1;
      @(negedge clk) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("busy after start", int'(busy), 1);
      for (int n = 1; n <= 1000; n++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = n;
            break;
         end
      end
      if (lat < 0) begin
         errors++;
         $display("FAIL sweep timeout: done never seen within 1000 cycles");
      end
   endtask

   initial begin
      int lat;
`ifdef CMP_SWEEP_HALT_ON_FAIL_EN
      tbl[0] = '{0,  0, 1, 0, 0, 0, 128, 7, 7};
      tbl[1] = '{1,  1, 0, 1, 0, 0,   2, 0, 0};
      tbl[2] = '{2,  1, 0, 1, 0, 1,   4, 0, 1};
      tbl[3] = '{3,  1, 0, 1, 0, 0,   2, 0, 0};
`else
      tbl[0] = '{0,  0, 1, 0, 0, 0, 128, 7, 7};
      tbl[1] = '{1, 36, 0, 1, 0, 0, 128, 7, 7};
      tbl[2] = '{2, 56, 0, 1, 0, 1, 128, 7, 7};
      tbl[3] = '{3,  8, 0, 1, 0, 0, 128, 7, 7};
`endif
      rst_n = 1'b0;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_zero("reset");
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < 4; i++) begin
         mode = tbl[i].mode;
         run_sweep(lat);
         chk($sformatf("m%0d latency", i),      lat,                  tbl[i].lat);
         chk($sformatf("m%0d err_count", i),    int'(err_count),      tbl[i].err);
         chk($sformatf("m%0d pass", i),         int'(pass),           tbl[i].pass);
         chk($sformatf("m%0d fail_seen", i),    int'(fail_seen),      tbl[i].fseen);
         chk($sformatf("m%0d first_fail_a", i), int'(first_fail_a),   tbl[i].ffa);
         chk($sformatf("m%0d first_fail_b", i), int'(first_fail_b),   tbl[i].ffb);
         chk($sformatf("m%0d busy in done", i), int'(busy),           1);
         @(posedge clk); #1;
         chk($sformatf("m%0d done pulse", i),   int'(done),           0);
         chk($sformatf("m%0d busy cleared", i), int'(busy),           0);
         chk($sformatf("m%0d hold a", i),       int'(cmp_a),          tbl[i].a);
         chk($sformatf("m%0d hold b", i),       int'(cmp_b),          tbl[i].b);
         chk($sformatf("m%0d pass hold", i),    int'(pass),           tbl[i].pass);
      end

      // Abort mid-sweep: a second start at cycle 20 must be ignored, reset at 40 clears all
      mode = 0;
      @(negedge clk) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (19) @(posedge clk);
      @(negedge clk) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("restart ignored idx", int'({cmp_a, cmp_b}), 10);
      chk("restart ignored busy", int'(busy), 1);
      repeat (19) @(posedge clk);
      @(negedge clk) rst_n = 1'b0;
      @(posedge clk); #1;
      check_zero("abort");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle stays idle", int'(busy), 0);

      run_sweep(lat);
      chk("post-abort latency",   lat,             128);
      chk("post-abort err_count", int'(err_count), 0);
      chk("post-abort pass",      int'(pass),      1);
      chk("post-abort fail_seen", int'(fail_seen), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cmp_sweep_ctrl.md
Name: cmp_sweep_ctrl

Overview:
- Sequencer that owns one `three_bit_comparator` instance's inputs and steps it through every {A,B} pair.
- Samples GT/LT/EQ after a programmable settle time and checks them against an internal reference.
- Reports an error count, the first failing pair and a pass flag.
- Sits beside the comparator as a built-in self-test controller, started by a single-cycle request.

Parameters:
- WIDTH, 3, operand width of A and B; the sweep covers 2^(2*WIDTH) vectors.
- SETTLE_CYCLES, 1, cycles (>=1) each vector is held before outputs are sampled.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  sweep request; sampled only in IDLE.
- cmp_a  output  WIDTH  A operand driven to the comparator (registered).
- cmp_b  output  WIDTH  B operand driven to the comparator (registered).
- cmp_gt  input  1  comparator GT result.
- cmp_lt  input  1  comparator LT result.
- cmp_eq  input  1  comparator EQ result.
- busy  output  1  high from start acceptance until DONE is left.
- done  output  1  one-cycle pulse when the sweep ends.
- pass  output  1  registered at DONE: err_count==0.
- err_count  output  2*WIDTH+1  mismatching vectors in the last sweep.
- fail_seen  output  1  at least one mismatch captured.
- first_fail_a  output  WIDTH  A of the first mismatching vector.
- first_fail_b  output  WIDTH  B of the first mismatching vector.

Behaviour:
- Reset: clk and rst_n as above; reset is synchronous and active-low.
  - On the edge where rst_n=0: state=IDLE, vector index=0, settle counter=0.
  - All outputs 0: cmp_a, cmp_b, busy, done, pass, err_count, fail_seen, first_fail_a, first_fail_b.
- Vector index idx is 2*WIDTH bits; {cmp_a,cmp_b}=idx, so B is the low half. Order is 0,1,...,2^(2W)-1.
- States: IDLE, DRIVE, CHECK, DONE.
  - IDLE:
    - start=1 -> DRIVE.
    - Same edge: idx=0, cmp_a=cmp_b=0, err_count=0, fail_seen=0, first_fail_*=0, pass=0, busy=1.
  - DRIVE:
    - Hold operands for SETTLE_CYCLES cycles (counter counts 0..SETTLE_CYCLES-1).
    - Then -> CHECK.
  - CHECK (1 cycle): sample cmp_gt/lt/eq against the expected triple {A>B, A<B, A==B}.
    - Any inequality counts as a mismatch, including non-one-hot outputs: err_count+1.
    - If fail_seen=0, capture first_fail_a/b and set fail_seen.
    - If idx is the last vector -> DONE. Otherwise idx+1, operands update on the same edge, -> DRIVE.
  - DONE (1 cycle): done=1, pass=(err_count==0 including this sweep), busy stays 1. Next edge -> IDLE, busy=0.
- Latency: done asserts 2^(2W)*(SETTLE_CYCLES+1) edges after the start-sampling edge (128 for defaults).
- start while not in IDLE is ignored; it is not queued.
- err_count width holds 2^(2W) exactly; no saturation needed.
- Operands hold the last vector after DONE until the next start.
- rst_n low mid-sweep aborts on that edge; results are lost and the controller returns to IDLE.

Optional Feature:
- Macro: CMP_SWEEP_HALT_ON_FAIL_EN.
- Defined: the first mismatch in CHECK goes directly to DONE instead of advancing. err_count ends at 1, pass=0, and operands hold the failing vector.
- Undefined: full sweep always completes as described.

Decomposition:
- Package cmp_sweep_pkg:
  - State enum (IDLE, DRIVE, CHECK, DONE).
  - localparam NUM_VEC = 2**(2*WIDTH) helper function.
  - expected-triple function.
- One sub-module, cmp_sweep_ref: combinational golden model that produces expected {gt,lt,eq} from cmp_a/cmp_b.
- The FSM, counters and capture registers stay in cmp_sweep_ctrl.

Test Plan:
- Correct comparator attached, start pulse -> done after 128 cycles, err_count=0, pass=1, fail_seen=0.
- cmp_gt tied 1, cmp_lt/eq tied 0 -> err_count=36, pass=0, first_fail=(0,0).
- GT and LT swapped -> err_count=56, first_fail_a=0, first_fail_b=1.
- cmp_eq stuck 0 -> err_count=8, first_fail=(0,0).
- rst_n low at cycle 40 of a sweep -> next edge all outputs 0, IDLE. start re-issued after cycle 20 is ignored while busy; a fresh start afterwards gives a full clean sweep (done at 128).
- CMP_SWEEP_HALT_ON_FAIL_EN defined, cmp_gt stuck 1 -> done 2 edges after start, err_count=1, cmp_a=cmp_b=0.
